// File: rtl/regfile_alloc_ctrl.sv
// regfile_alloc_ctrl: maps in-flight ROB tags to their architectural destination
// registers and drives the regfile allocate / load / flush-recovery ports.
// Dispatch claims a tag, commit releases it, and a flush re-validates every
// pending destination and then holds dispatch off for a short drain window.
module regfile_alloc_ctrl #(
  parameter  int ROB_DEPTH = 8,
  parameter  int DRAIN_CYC = 2,
  localparam int TAG_W     = $clog2(ROB_DEPTH),
  localparam int INF_W     = $clog2(ROB_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   disp_valid,
  input  logic [4:0]             disp_rd,
  input  logic [TAG_W-1:0]       disp_tag,
  output logic                   disp_ready,
  input  logic                   cmt_valid,
  input  logic [TAG_W-1:0]       cmt_tag,
  input  logic                   flush_req,
  output logic                   allocate,
  output logic [4:0]             reg_allocate,
  output logic [TAG_W-1:0]       tag_in,
  output logic                   load,
  output logic [4:0]             dest,
  output logic [TAG_W-1:0]       commit_tag,
  output logic                   flush_ip,
  output logic [ROB_DEPTH-1:0]   set_reg_valid,
  output logic [ROB_DEPTH*5-1:0] reg_valid,
  output logic [INF_W-1:0]       inflight,
  output logic                   flush_done
);

  localparam int CNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [ROB_DEPTH-1:0] busy_q, busy_d;
  logic [4:0]           rd_q [ROB_DEPTH];
  logic [4:0]           rd_d [ROB_DEPTH];
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 flush_done_q, flush_done_d;
  logic                 cmt_hit;

  // State register and tag table.
  // NOTE: the tag table is only 8 entries and an empty table is the defined
  // reset state, so it is cleared by reset along with the FSM; nonblocking
  // assignments keep every register sampling the pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      busy_q       <= '0;
      cnt_q        <= '0;
      flush_done_q <= 1'b0;
      for (int i = 0; i < ROB_DEPTH; i++) rd_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      cnt_q        <= cnt_d;
      flush_done_q <= flush_done_d;
      for (int i = 0; i < ROB_DEPTH; i++) rd_q[i] <= rd_d[i];
    end
  end

  // Next-state logic and regfile-side strobes.
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q;
    rd_d          = rd_q;
    cnt_d         = cnt_q;
    flush_done_d  = 1'b0;
    disp_ready    = 1'b0;
    allocate      = 1'b0;
    load          = 1'b0;
    flush_ip      = 1'b0;
    set_reg_valid = '0;
    reg_valid     = '0;
    reg_allocate  = disp_rd;
    tag_in        = disp_tag;
    dest          = rd_q[cmt_tag];
    commit_tag    = cmt_tag;
    cmt_hit       = cmt_valid & busy_q[cmt_tag];

    case (state_q)
      IDLE: begin
        // A busy tag cannot be reissued until its own commit frees it.
        disp_ready = !flush_req && !busy_q[disp_tag];
        if (disp_valid && disp_ready) begin
          // rd==0 still occupies the tag so inflight stays exact.
          allocate         = (disp_rd != 5'd0);
          busy_d[disp_tag] = 1'b1;
          rd_d[disp_tag]   = disp_rd;
        end
        // Commit and dispatch can never hit the same tag in one cycle:
        // dispatch needs the tag free, commit needs it busy.
        if (cmt_hit) begin
          load            = (rd_q[cmt_tag] != 5'd0);
          busy_d[cmt_tag] = 1'b0;
        end
        if (flush_req) state_d = FLUSH;
      end

      FLUSH: begin
        flush_ip = 1'b1;
        for (int i = 0; i < ROB_DEPTH; i++) begin
          if (busy_q[i] && (rd_q[i] != 5'd0)) begin
            set_reg_valid[i]   = 1'b1;
            reg_valid[i*5 +: 5] = rd_q[i];
          end
        end
        busy_d  = '0;
        cnt_d   = CNT_W'(DRAIN_CYC - 1);
        state_d = DRAIN;
      end

      DRAIN: begin
        // Table is empty here, so commits have nothing to release.
        if (cnt_q == '0) begin
          state_d      = IDLE;
          flush_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Occupancy count of the tag table.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < ROB_DEPTH; i++) inflight = inflight + INF_W'(busy_q[i]);
  end

  // flush_done is registered so it pulses in the first cycle dispatch reopens.
  assign flush_done = flush_done_q;

endmodule

// File: tb/tb_regfile_alloc_ctrl.sv
// Testbench for regfile_alloc_ctrl: table-driven vectors pushed through an
// expected-result queue, plus hand-built flush and reset-in-drain sequences.
module tb_regfile_alloc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        disp_valid, cmt_valid, flush_req;
  logic [4:0]  disp_rd;
  logic [2:0]  disp_tag, cmt_tag;
  logic        disp_ready, allocate, load, flush_ip, flush_done;
  logic [4:0]  reg_allocate, dest;
  logic [2:0]  tag_in, commit_tag;
  logic [7:0]  set_reg_valid;
  logic [39:0] reg_valid;
  logic [3:0]  inflight;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_alloc_ctrl #(.ROB_DEPTH(8), .DRAIN_CYC(2)) dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_rd(disp_rd), .disp_tag(disp_tag),
    .disp_ready(disp_ready),
    .cmt_valid(cmt_valid), .cmt_tag(cmt_tag), .flush_req(flush_req),
    .allocate(allocate), .reg_allocate(reg_allocate), .tag_in(tag_in),
    .load(load), .dest(dest), .commit_tag(commit_tag),
    .flush_ip(flush_ip), .set_reg_valid(set_reg_valid), .reg_valid(reg_valid),
    .inflight(inflight), .flush_done(flush_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dv;
    logic [4:0]  drd;
    logic [2:0]  dtag;
    logic        cv;
    logic [2:0]  ctag;
    logic        fr;
    logic        e_ready;
    logic        e_alloc;
    logic        e_load;
    logic [4:0]  e_dest;
    logic        e_fip;
    logic        e_fdone;
    logic [3:0]  e_infl;
    logic [7:0]  e_srv;
    logic [39:0] e_rv;
  } vec_t;

  vec_t exp_q[$];
  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic dv, input logic [4:0] drd, input logic [2:0] dtag,
                              input logic cv, input logic [2:0] ctag, input logic fr,
                              input logic e_ready, input logic e_alloc, input logic e_load,
                              input logic [4:0] e_dest, input logic e_fip, input logic e_fdone,
                              input logic [3:0] e_infl, input logic [7:0] e_srv,
                              input logic [39:0] e_rv);
    vec_t v;
    v.dv = dv; v.drd = drd; v.dtag = dtag; v.cv = cv; v.ctag = ctag; v.fr = fr;
    v.e_ready = e_ready; v.e_alloc = e_alloc; v.e_load = e_load; v.e_dest = e_dest;
    v.e_fip = e_fip; v.e_fdone = e_fdone; v.e_infl = e_infl; v.e_srv = e_srv; v.e_rv = e_rv;
    return v;
  endfunction

  // Drive one cycle of stimulus (called just after a posedge), queue its
  // expectation, compare on the falling edge, then return just after the next posedge.
  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    disp_valid = v.dv; disp_rd = v.drd; disp_tag = v.dtag;
    cmt_valid  = v.cv; cmt_tag = v.ctag; flush_req = v.fr;
    exp_q.push_back(v);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check({tag, ".queue"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, ".disp_ready"}, 64'(disp_ready), 64'(e.e_ready));
      check({tag, ".allocate"},   64'(allocate),   64'(e.e_alloc));
      if (e.e_alloc) begin
        check({tag, ".reg_allocate"}, 64'(reg_allocate), 64'(e.drd));
        check({tag, ".tag_in"},       64'(tag_in),       64'(e.dtag));
      end
      check({tag, ".load"}, 64'(load), 64'(e.e_load));
      if (e.e_load) begin
        check({tag, ".dest"},       64'(dest),       64'(e.e_dest));
        check({tag, ".commit_tag"}, 64'(commit_tag), 64'(e.ctag));
      end
      check({tag, ".flush_ip"},      64'(flush_ip),      64'(e.e_fip));
      check({tag, ".flush_done"},    64'(flush_done),    64'(e.e_fdone));
      check({tag, ".inflight"},      64'(inflight),      64'(e.e_infl));
      check({tag, ".set_reg_valid"}, 64'(set_reg_valid), 64'(e.e_srv));
      check({tag, ".reg_valid"},     64'(reg_valid),     64'(e.e_rv));
    end
    @(posedge clk);
    #1;
  endtask

  // Idle cycle with a given disp_tag probe and expected ready/flush_done/inflight.
  function automatic vec_t idle(input logic [2:0] dtag, input logic rdy,
                                input logic fdone, input logic [3:0] infl);
    return mk(0, 5'd0, dtag, 0, 3'd0, 0, rdy, 0, 0, 5'd0, 0, fdone, infl, 8'h00, 40'd0);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    disp_valid = 0; disp_rd = '0; disp_tag = '0;
    cmt_valid = 0; cmt_tag = '0; flush_req = 0;

    // Basic dispatch / commit table.
    //           dv drd   dtag cv ctag fr  rdy al ld dest fip fd infl srv rv
    vecs[0]  = mk(0, 5'd0, 3'd0, 0, 3'd0, 0, 1, 0, 0, 5'd0, 0, 0, 4'd0, 8'h00, 40'd0);
    vecs[1]  = mk(1, 5'd5, 3'd2, 0, 3'd0, 0, 1, 1, 0, 5'd0, 0, 0, 4'd0, 8'h00, 40'd0);
    vecs[2]  = mk(1, 5'd5, 3'd2, 0, 3'd0, 0, 0, 0, 0, 5'd0, 0, 0, 4'd1, 8'h00, 40'd0);
    vecs[3]  = mk(0, 5'd0, 3'd0, 1, 3'd2, 0, 1, 0, 1, 5'd5, 0, 0, 4'd1, 8'h00, 40'd0);
    vecs[4]  = mk(0, 5'd0, 3'd0, 1, 3'd4, 0, 1, 0, 0, 5'd0, 0, 0, 4'd0, 8'h00, 40'd0);
    vecs[5]  = mk(1, 5'd5, 3'd2, 0, 3'd0, 0, 1, 1, 0, 5'd0, 0, 0, 4'd0, 8'h00, 40'd0);
    vecs[6]  = mk(1, 5'd7, 3'd3, 1, 3'd2, 0, 1, 1, 1, 5'd5, 0, 0, 4'd1, 8'h00, 40'd0);
    vecs[7]  = mk(0, 5'd0, 3'd0, 0, 3'd0, 0, 1, 0, 0, 5'd0, 0, 0, 4'd1, 8'h00, 40'd0);
    vecs[8]  = mk(0, 5'd0, 3'd0, 1, 3'd3, 0, 1, 0, 1, 5'd7, 0, 0, 4'd1, 8'h00, 40'd0);
    vecs[9]  = mk(1, 5'd0, 3'd5, 0, 3'd0, 0, 1, 0, 0, 5'd0, 0, 0, 4'd0, 8'h00, 40'd0);
    vecs[10] = mk(0, 5'd0, 3'd5, 0, 3'd0, 0, 0, 0, 0, 5'd0, 0, 0, 4'd1, 8'h00, 40'd0);
    vecs[11] = mk(0, 5'd0, 3'd0, 1, 3'd5, 0, 1, 0, 0, 5'd0, 0, 0, 4'd1, 8'h00, 40'd0);
    vecs[12] = mk(0, 5'd0, 3'd0, 0, 3'd0, 0, 1, 0, 0, 5'd0, 0, 0, 4'd0, 8'h00, 40'd0);

    // Reset: outputs held low while rst is asserted.
    repeat (2) @(posedge clk);
    #1;
    check("rst.allocate", 64'(allocate), 64'd0);
    check("rst.load", 64'(load), 64'd0);
    check("rst.flush_ip", 64'(flush_ip), 64'd0);
    check("rst.flush_done", 64'(flush_done), 64'd0);
    check("rst.inflight", 64'(inflight), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Flush with tags 0,1,6 busy (rd 3,0,9) plus tag 4 (rd 8) committed in the flush_req cycle.
    apply(mk(1, 5'd3, 3'd0, 0, 3'd0, 0, 1, 1, 0, 5'd0, 0, 0, 4'd0, 8'h00, 40'd0), "fl.d0");
    apply(mk(1, 5'd0, 3'd1, 0, 3'd0, 0, 1, 0, 0, 5'd0, 0, 0, 4'd1, 8'h00, 40'd0), "fl.d1");
    apply(mk(1, 5'd9, 3'd6, 0, 3'd0, 0, 1, 1, 0, 5'd0, 0, 0, 4'd2, 8'h00, 40'd0), "fl.d6");
    apply(mk(1, 5'd8, 3'd4, 0, 3'd0, 0, 1, 1, 0, 5'd0, 0, 0, 4'd3, 8'h00, 40'd0), "fl.d4");
    // flush_req: dispatch refused, commit of tag 4 honoured.
    apply(mk(1, 5'd4, 3'd7, 1, 3'd4, 1, 0, 0, 1, 5'd8, 0, 0, 4'd4, 8'h00, 40'd0), "fl.req");
    // FLUSH cycle: re-validate tags 0 and 6; commit of busy tag 0 must not load.
    apply(mk(1, 5'd4, 3'd7, 1, 3'd0, 0, 0, 0, 0, 5'd0, 1, 0, 4'd3, 8'h41,
             40'd3 | (40'd9 << 30)), "fl.flush");
    // DRAIN: a second flush_req here is ignored.
    apply(mk(1, 5'd4, 3'd7, 0, 3'd0, 1, 0, 0, 0, 5'd0, 0, 0, 4'd0, 8'h00, 40'd0), "fl.drain1");
    apply(mk(1, 5'd4, 3'd7, 0, 3'd0, 0, 0, 0, 0, 5'd0, 0, 0, 4'd0, 8'h00, 40'd0), "fl.drain2");
    apply(idle(3'd0, 1, 1, 4'd0), "fl.reopen");
    apply(idle(3'd0, 1, 0, 4'd0), "fl.after");

    // Reset asserted during DRAIN: back to IDLE at once, no flush_done pulse.
    apply(mk(1, 5'd2, 3'd1, 0, 3'd0, 0, 1, 1, 0, 5'd0, 0, 0, 4'd0, 8'h00, 40'd0), "rd.d1");
    apply(mk(0, 5'd0, 3'd0, 0, 3'd0, 1, 0, 0, 0, 5'd0, 0, 0, 4'd1, 8'h00, 40'd0), "rd.req");
    apply(mk(0, 5'd0, 3'd0, 0, 3'd0, 0, 0, 0, 0, 5'd0, 1, 0, 4'd1, 8'h02,
             40'd2 << 5), "rd.flush");
    check("rd.in_drain.disp_ready", 64'(disp_ready), 64'd0);
    rst = 1'b0;
    #2;
    check("rd.rst.flush_done", 64'(flush_done), 64'd0);
    check("rd.rst.flush_ip", 64'(flush_ip), 64'd0);
    check("rd.rst.inflight", 64'(inflight), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) apply(idle(3'd1, 1, 0, 4'd0), $sformatf("rd.post%0d", i));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
